// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//
// Shared definitions for the VGA raster timing generator:
//   - vga_timing_t   : per-axis active / front porch / sync / back porch widths
//   - VGA_640x480_60 : standard 640x480 @ 60 Hz mode (25.175 MHz pixel clock)
//   - SVGA_800x600_60: standard 800x600 @ 60 Hz mode (40 MHz pixel clock)
//   - SYNC_ACT_LOW / SYNC_ACT_HIGH : sync polarity selectors
//   - axis_total()   : total positions on one axis
//   - width_of()     : counter width for a modulus, never less than one bit
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
    };

    localparam vga_timing_t SVGA_800x600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
    };

    localparam bit SYNC_ACT_LOW  = 1'b0;
    localparam bit SYNC_ACT_HIGH = 1'b1;

    // Number of positions on one axis (visible + blanking).
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to count 0..n-1; a modulus of 1 still gets one bit so the
    // counter stays a legal vector.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//
// One raster axis: a position counter that advances on inc and wraps
// TOTAL-1 -> 0, plus the combinational decode of that position.
//
// Parameters
//   TOTAL      : positions on the axis
//   ACTIVE     : visible positions (0..ACTIVE-1)
//   SYNC_START : first position of the sync pulse
//   SYNC_END   : first position after the sync pulse
//   POL        : active level of sync (SYNC_ACT_LOW / SYNC_ACT_HIGH)
//   W          : position width
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   inc        : advance the position by one
//   wrap       : position is TOTAL-1 (the next inc returns it to 0)
//   pos        : current position
//   in_active  : position lies inside the visible window
//   sync       : sync level at the current position, already at polarity POL
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter bit POL        = SYNC_ACT_LOW,
    parameter int W          = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic         wrap,
    output logic [W-1:0] pos,
    output logic         in_active,
    output logic         sync
);

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG = W'(SYNC_START);
    localparam logic [W-1:0] SYNC_FIN = W'(SYNC_END);

    // NOTE: the reset is in the sensitivity list, so it takes effect the
    // moment rst rises rather than waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (inc) begin
            // NOTE: non-blocking assignment for all clocked state, so every
            // register samples pre-edge values regardless of statement order.
            pos <= wrap ? '0 : pos + 1'b1;
        end
    end

    assign wrap      = (pos == LAST);
    assign in_active = (pos < ACT_END);
    assign sync      = ((pos >= SYNC_BEG) && (pos < SYNC_FIN)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. A pixel-clock divider produces
// pix_tick; two vga_axis_counter instances track the raster position (h, v);
// on each pix_tick every output is registered together from the pre-increment
// position, so x/y/de/syncs/strobes always describe the same pixel.
//
// Parameters
//   H_ACTIVE, H_FP, H_SYNC, H_BP : horizontal timing, in pixels
//   V_ACTIVE, V_FP, V_SYNC, V_BP : vertical timing, in lines
//   HSYNC_POL, VSYNC_POL         : active sync level (0 = active-low)
//   PIX_DIV                      : clocks per pixel (>= 1)
//   FRAME_W                      : frame counter width
//
// Ports
//   clk         : clock
//   rst         : asynchronous active-high reset
//   en          : advance enable; low freezes the divider, counters, outputs
//   hsync/vsync : sync outputs at the configured polarity
//   de          : visible-window indicator
//   x, y        : raw raster position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   line_start  : one-clock pulse when a pixel with x == 0 is loaded
//   frame_start : one-clock pulse when pixel (0,0) is loaded
//   frame_cnt   : completed-frame counter, wraps modulo 2^FRAME_W
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = int'(VGA_640x480_60.h_active),
    parameter int H_FP      = int'(VGA_640x480_60.h_fp),
    parameter int H_SYNC    = int'(VGA_640x480_60.h_sync),
    parameter int H_BP      = int'(VGA_640x480_60.h_bp),
    parameter int V_ACTIVE  = int'(VGA_640x480_60.v_active),
    parameter int V_FP      = int'(VGA_640x480_60.v_fp),
    parameter int V_SYNC    = int'(VGA_640x480_60.v_sync),
    parameter int V_BP      = int'(VGA_640x480_60.v_bp),
    parameter bit HSYNC_POL = SYNC_ACT_LOW,
    parameter bit VSYNC_POL = SYNC_ACT_LOW,
    parameter int PIX_DIV   = 1,
    parameter int FRAME_W   = 8,
    localparam int H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [HW-1:0]      x,
    output logic [VW-1:0]      y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    // Zero-width porches or syncs would collapse the sync decode and a zero
    // divider has no meaning, so refuse to elaborate such a configuration.
    if ((PIX_DIV < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
        (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_params
        $error("vga_timing_gen: PIX_DIV and every porch/sync width must be >= 1");
    end

    localparam int DIV_W = width_of(PIX_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    // -------------------------------------------------------------------------
    // Pixel-clock divider
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] div;
    logic             pix_tick;

    // With PIX_DIV == 1, DIV_LAST is 0 and div never leaves 0, so pix_tick
    // degenerates to en.
    assign pix_tick = en && (div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (en) begin
            div <= pix_tick ? '0 : div + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Raster position
    // -------------------------------------------------------------------------
    logic          h_wrap, h_act, h_sync;
    logic          v_wrap, v_act, v_sync;
    logic [HW-1:0] h_pos;
    logic [VW-1:0] v_pos;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC),
        .POL        (HSYNC_POL),
        .W          (HW)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .inc       (pix_tick),
        .wrap      (h_wrap),
        .pos       (h_pos),
        .in_active (h_act),
        .sync      (h_sync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC),
        .POL        (VSYNC_POL),
        .W          (VW)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .inc       (pix_tick && h_wrap),
        .wrap      (v_wrap),
        .pos       (v_pos),
        .in_active (v_act),
        .sync      (v_sync)
    );

    logic at_origin;
    assign at_origin = (h_pos == '0) && (v_pos == '0);

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    // frame_seen records that at least one full frame has been scanned since
    // reset. The very first (0,0) load after reset starts frame 0 rather than
    // completing one, so frame_cnt only advances on origin loads that follow
    // a frame wrap.
    logic frame_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            frame_seen  <= 1'b0;
        end else begin
            // NOTE: strobes default low every clock and are only raised on a
            // qualifying pix_tick, which keeps them single-clock pulses and
            // holds them at 0 throughout a pause.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_tick) begin
                x           <= h_pos;
                y           <= v_pos;
                de          <= h_act && v_act;
                hsync       <= h_sync;
                vsync       <= v_sync;
                line_start  <= (h_pos == '0);
                frame_start <= at_origin;
                if (at_origin && frame_seen) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
                if (h_wrap && v_wrap) begin
                    frame_seen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances of the small test mode (H 8/2/3/1, V 4/1/2/1, FRAME_W 2):
//   dut_a : PIX_DIV 1, both syncs active-low
//   dut_b : PIX_DIV 3, hsync active-high
// They share clk, rst and en. The stimulus process drives en once per clock,
// derives the expected outputs of both instances from the number of enabled
// clocks since reset, and queues them; the monitor pops one entry after every
// clock edge and compares it against both instances.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 1;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 14
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 8
    localparam int FT = HT * VT;                           // 112
    localparam int DIV_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    logic       hs_a, vs_a, de_a, ls_a, fs_a;
    logic [3:0] x_a;
    logic [2:0] y_a;
    logic [1:0] fc_a;
    logic       hs_b, vs_b, de_b, ls_b, fs_b;
    logic [3:0] x_b;
    logic [2:0] y_b;
    logic [1:0] fc_b;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(SYNC_ACT_LOW), .VSYNC_POL(SYNC_ACT_LOW),
        .PIX_DIV(1), .FRAME_W(2)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(SYNC_ACT_HIGH), .VSYNC_POL(SYNC_ACT_LOW),
        .PIX_DIV(DIV_B), .FRAME_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] x;
        logic [2:0] y;
        logic       ls;
        logic       fs;
        logic [1:0] fc;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
        int   n;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_en      = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   last_ls_a = -1;
    int   last_ls_b = -1;
    int   last_fs_a = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Expected outputs after n enabled clocks since reset. Pixel index p is
    // the (p+1)-th pixel tick, scanning the raster row by row.
    function automatic obs_t model(input int n, input bit en_edge, input int pdiv, input bit hpol);
        obs_t o;
        int   p, px, py;
        bit   tick_now;
        o    = '0;
        o.hs = ~hpol;
        o.vs = 1'b1;
        if (n / pdiv == 0) return o;
        p  = n / pdiv - 1;
        px = p % HT;
        py = (p / HT) % VT;
        o.x  = 4'(px);
        o.y  = 3'(py);
        o.fc = 2'((p / FT) % 4);
        o.de = (px < H_ACTIVE) && (py < V_ACTIVE);
        o.hs = (px >= H_ACTIVE + H_FP && px < H_ACTIVE + H_FP + H_SYNC) ? hpol : ~hpol;
        o.vs = (py >= V_ACTIVE + V_FP && py < V_ACTIVE + V_FP + V_SYNC) ? 1'b0 : 1'b1;
        tick_now = en_edge && (n % pdiv == 0);
        o.ls = tick_now && (px == 0);
        o.fs = tick_now && (p % FT == 0);
        return o;
    endfunction

    function automatic obs_t get_a();
        return {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, fc_a};
    endfunction

    function automatic obs_t get_b();
        return {hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b, fc_b};
    endfunction

    task automatic cmp_obs(input string tag, input obs_t act, input obs_t want);
        check({tag, ".hsync"},       32'(act.hs), 32'(want.hs));
        check({tag, ".vsync"},       32'(act.vs), 32'(want.vs));
        check({tag, ".de"},          32'(act.de), 32'(want.de));
        check({tag, ".x"},           32'(act.x),  32'(want.x));
        check({tag, ".y"},           32'(act.y),  32'(want.y));
        check({tag, ".line_start"},  32'(act.ls), 32'(want.ls));
        check({tag, ".frame_start"}, 32'(act.fs), 32'(want.fs));
        check({tag, ".frame_cnt"},   32'(act.fc), 32'(want.fc));
    endtask

    task automatic check_reset(input string tag);
        cmp_obs({tag, "_a"}, get_a(), model(0, 1'b0, 1, SYNC_ACT_LOW));
        cmp_obs({tag, "_b"}, get_b(), model(0, 1'b0, DIV_B, SYNC_ACT_HIGH));
    endtask

    // One clock of stimulus: set en for the coming edge and queue the
    // outputs both instances must show after it.
    task automatic step(input bit e);
        exp_t ex;
        @(negedge clk);
        en = e;
        if (e) n_en++;
        ex.a = model(n_en, e, 1, SYNC_ACT_LOW);
        ex.b = model(n_en, e, DIV_B, SYNC_ACT_HIGH);
        ex.n = n_en;
        sb_q.push_back(ex);
        last_exp = ex;
    endtask

    // Monitor: compares one queued expectation per clock edge, and checks the
    // strobe periods measured in enabled clocks.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                cmp_obs("a", get_a(), e.a);
                cmp_obs("b", get_b(), e.b);
                if (ls_a) begin
                    if (last_ls_a >= 0) check("a.line_period", 32'(e.n - last_ls_a), 32'(HT));
                    last_ls_a = e.n;
                end
                if (ls_b) begin
                    if (last_ls_b >= 0) check("b.line_period", 32'(e.n - last_ls_b), 32'(HT * DIV_B));
                    last_ls_b = e.n;
                end
                if (fs_a) begin
                    if (last_fs_a >= 0) check("a.frame_period", 32'(e.n - last_fs_a), 32'(FT));
                    last_fs_a = e.n;
                end
            end
        end
    end

    initial begin : stimulus
        // Reset asserted before any clock edge: outputs must respond at once.
        #2 rst = 1'b1;
        #1 check_reset("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Free run with en held high: more than four frames of dut_a.
        repeat (600) step(1'b1);

        // Random enable pattern, about 75% high.
        repeat (900) step($urandom_range(0, 3) != 0);

        // Pause while dut_a shows x == 5.
        for (int k = 0; k < HT + 1; k++) begin
            step(1'b1);
            if (last_exp.a.x == 4'd5) break;
        end
        repeat (7) step(1'b0);
        step(1'b1);
        @(posedge clk);
        #2 check("pause_resume_x", 32'(x_a), 32'd6);

        // Asynchronous reset mid-frame, once dut_a is at (9,3).
        for (int k = 0; k < FT + 1; k++) begin
            step(1'b1);
            if (last_exp.a.x == 4'd9 && last_exp.a.y == 3'd3) break;
        end
        @(posedge clk);
        #3;
        rst       = 1'b1;
        n_en      = 0;
        last_ls_a = -1;
        last_ls_b = -1;
        last_fs_a = -1;
        #1 check_reset("midframe_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;

        // Restart from (0,0) with frame_cnt back at 0.
        repeat (400) step(1'b1);
        repeat (300) step($urandom_range(0, 4) != 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the tt_um_vga_example family of designs. It produces horizontal and vertical sync, the data-enable window, raw pixel coordinates and line/frame strobes for any mode described by porch and sync widths. Relative to the fixed 640x480 counters in earlier designs it adds:
- configurable sync polarity;
- a pixel-clock divider;
- an enable/pause input;
- a wrapping frame counter.

It sits between the top-level clock/reset and the pixel-generation logic, which consumes `x`, `y`, `de` and the strobes.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal front porch, sync width and back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical front porch, sync width and back porch, in lines
- `HSYNC_POL`, 0 / `VSYNC_POL`, 0: active level of each sync (0 = active-low)
- `PIX_DIV`, 1: clocks per pixel (≥1)
- `FRAME_W`, 8: frame counter width
- Derived localparams:
  - `H_TOTAL` = sum of the four H parameters; `V_TOTAL` likewise.
  - `HW` = $clog2(`H_TOTAL`); `VW` = $clog2(`V_TOTAL`).
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous, active-high
- `en` in 1: advance enable; when low, all state holds
- `hsync` out 1: horizontal sync, at polarity `HSYNC_POL`
- `vsync` out 1: vertical sync, at polarity `VSYNC_POL`
- `de` out 1: high inside the active window
- `x` out `HW`: raw horizontal position, 0..`H_TOTAL`-1
- `y` out `VW`: raw vertical position, 0..`V_TOTAL`-1
- `line_start` out 1: one-clock pulse when the outputs load x==0
- `frame_start` out 1: one-clock pulse when the outputs load (0,0)
- `frame_cnt` out `FRAME_W`: completed-frame counter, wraps modulo 2^`FRAME_W`

## Operation
- **Divider:** `pix_tick` fires when `div == PIX_DIV-1` and `en=1`; `div` then returns to 0. With `PIX_DIV=1`, `pix_tick = en`.
- **Counters:** internal counters `h` and `v` advance on `pix_tick`.
  - `h` wraps `H_TOTAL-1` → 0.
  - `v` increments only on the `h` wrap, and wraps `V_TOTAL-1` → 0.
- **Output load:** on each `pix_tick`, all position outputs are registered together from the pre-increment (`h`,`v`). Outputs are therefore always mutually consistent.
  - `x = h`, `y = v`.
  - `de = (h < H_ACTIVE) && (v < V_ACTIVE)`.
  - `hsync` is active while `H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC`; `vsync` uses the same rule on `v`.
- **Strobes:** `line_start` and `frame_start` are high for exactly the one clock following a load of h==0 (respectively h==0 and v==0). They are 0 on every other clock, including all clocks while `en=0`.
- **Frame counter:** `frame_cnt` increments on the same edge that raises `frame_start`, except on the first `frame_start` after reset.
- **Pause:** `en=0` freezes `div`, `h`, `v` and all outputs. Advance resumes exactly where it stopped.
- **Reset:** asynchronous assertion (at any point, including mid-frame) forces all of the following immediately, independent of `clk`:
  - `div`=0, `h`=0, `v`=0
  - `x`=0, `y`=0, `de`=0
  - `hsync`=~`HSYNC_POL`, `vsync`=~`VSYNC_POL`
  - strobes 0, `frame_cnt`=0

## Timing
- The first `pix_tick` after reset release (the first `en`-high edge when `PIX_DIV=1`) loads position (0,0). On that edge `de`=1, `line_start`=1 and `frame_start`=1, and `frame_cnt` stays 0.
- Each position is held for `PIX_DIV` enabled clocks.
- Line period is `H_TOTAL·PIX_DIV` enabled clocks; frame period is `H_TOTAL·V_TOTAL·PIX_DIV` enabled clocks.
- Latency is one clock from counter state to outputs. There is no other pipelining.
- Elaboration-time error if `PIX_DIV<1` or if any porch or sync parameter is less than 1.

## Structure
- **Package `vga_pkg`:**
  - `vga_timing_t` struct with the active, fp, sync and bp fields per axis;
  - preset constants `VGA_640x480_60` and `SVGA_800x600_60`;
  - polarity constants `SYNC_ACT_LOW` and `SYNC_ACT_HIGH`.
- **Sub-module `vga_axis_counter`:**
  - Parameters: total, sync start, sync end, active, polarity.
  - Ports: `inc` in, `wrap` out, `pos`, `in_active`, `sync`.
  - Instantiated twice: horizontal with `inc = pix_tick`; vertical with `inc = pix_tick && h_wrap`.

## Test plan
Small mode unless stated: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), `PIX_DIV`=1, polarity 0, `FRAME_W`=2, `en`=1.
- **Reset state and start:** assert `rst` → `hsync`=1, `vsync`=1, `de`=0, `x`=`y`=0, strobes 0. Release `rst`; the first edge gives `x`=0, `y`=0, `de`=1, `line_start`=1, `frame_start`=1, `frame_cnt`=0.
- **Line timing:**
  - `de` is high for `x`=0..7 and low for `x`=8..13.
  - `hsync` is 0 exactly for `x`=10..12.
  - `line_start` pulses every 14 clocks.
- **Frame timing:**
  - `de` is never high for `y`≥4.
  - `vsync` is 0 for `y`=5..6, i.e. 28 clocks.
  - `frame_start` pulses every 112 clocks.
  - `frame_cnt` goes 1, 2, 3, 0 over four frames.
- **Divider and polarity:** `PIX_DIV`=3 and `HSYNC_POL`=1 → each `x` is held for 3 clocks, `line_start` repeats every 42 clocks, and `hsync` is 1 only for `x`=10..12.
- **Pause:** drop `en` for 7 clocks while `x`=5 → `x` stays 5, all outputs hold, strobes stay 0. After `en` returns, the next edge gives `x`=6.
- **Mid-frame reset:** assert `rst` asynchronously at (9,3) → all outputs reach reset values before the next `clk` edge. After release the sequence restarts at (0,0) with `frame_cnt`=0.
